modulo_slot_scheduler: RTL and testbench

Time-slice round-robin scheduler that shares one resource (e.g. a modulo-k counter datapath or its downstream consumer) between N requesters. Each granted requester owns the resource for at most SLOT_LEN cycles, measured by an internal modulo counter. Ownership ends early on `done` or request withdrawal. Every ownership change is followed by a fixed GAP_LEN-cycle handover gap. The block sits between the requester ports and the shared datapath and drives its one-hot select.

---
 rtl/sched_pkg.sv | 35 +++
 rtl/slot_counter.sv | 25 ++
 rtl/modulo_slot_scheduler.sv | 101 ++++++++++
 tb/tb_modulo_slot_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and the round-robin search used by the slot scheduler.
// rr_pick scans from last+1 upward with wrap and returns the first requester found.
package sched_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    localparam int MAX_N = 64;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input int unsigned      last,
                                      input int unsigned      n);
        pick_t       p;
        int unsigned idx;
        p = '0;
        for (int unsigned i = 1; i <= MAX_N; i++) begin
            if (i <= n) begin
                idx = last + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!p.found && req[idx]) begin
                    p.found = 1'b1;
                    p.idx   = idx[5:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/slot_counter.sv
// 32-bit cycle counter that wraps to zero when it reaches a runtime limit.
// Clear has priority over enable.
module slot_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limit,
    output logic [31:0] count,
    output logic        wrap
);

    assign wrap = (count == limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? 32'd0 : count + 32'd1;
        end
    end

endmodule

// File: rtl/modulo_slot_scheduler.sv
// Time-sliced round-robin owner of a shared resource: bounded slots, early release,
// and a fixed dead gap after every ownership change.
module modulo_slot_scheduler
    import sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int SLOT_LEN = 16,
    parameter int GAP_LEN  = 1,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic [31:0]    slot_count,
    output logic           preempt
);

    localparam logic [31:0] SLOT_LIM = 32'(SLOT_LEN - 1);
    localparam logic [31:0] GAP_LIM  = 32'(GAP_LEN - 1);

    state_t           state;
    logic [IDW-1:0]   last;
    logic [MAX_N-1:0] req_ext;
    pick_t            pick;
    logic             owner_release;
    logic             cnt_clr;
    logic             cnt_en;
    logic [31:0]      cnt_limit;
    logic             cnt_wrap;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_pick(req_ext, int'(last), N);
    end

    // Only the current owner's done/req matter; everyone else is ignored.
    assign owner_release = (state == BUSY) && (done[grant_id] || !req[grant_id]);

    // One counter serves both phases; the limit follows the phase.
    assign cnt_clr   = (state == IDLE) || owner_release;
    assign cnt_en    = (state != IDLE);
    assign cnt_limit = (state == GAP) ? GAP_LIM : SLOT_LIM;

    slot_counter u_slot_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (cnt_limit),
        .count   (slot_count),
        .wrap    (cnt_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last        <= IDW'(N - 1);
            preempt     <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick.found) begin
                        grant       <= {{(N-1){1'b0}}, 1'b1} << pick.idx;
                        grant_valid <= 1'b1;
                        grant_id    <= IDW'(pick.idx);
                        last        <= IDW'(pick.idx);
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (owner_release) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        state       <= GAP;
                    end else if (cnt_wrap) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        preempt     <= 1'b1;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    if (cnt_wrap) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_slot_scheduler.sv
// Bench for modulo_slot_scheduler: two instances (slot 4/gap 1 and slot 1/gap 3)
// checked cycle by cycle against an ownership-level reference model.
module tb_modulo_slot_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_a, done_a, req_b, done_b;
    logic [3:0]  grant_a, grant_b;
    logic        grant_valid_a, grant_valid_b;
    logic [1:0]  grant_id_a, grant_id_b;
    logic [31:0] slot_count_a, slot_count_b;
    logic        preempt_a, preempt_b;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model: who owns the resource, for how long, and gap progress.
    int m_owner[2];
    int m_run[2];
    int m_gap[2];
    int m_last[2];
    int m_id[2];
    bit m_pre[2];

    always #5 clk = ~clk;

    modulo_slot_scheduler #(.N(4), .SLOT_LEN(4), .GAP_LEN(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req_a), .done(done_a),
        .grant(grant_a), .grant_valid(grant_valid_a), .grant_id(grant_id_a),
        .slot_count(slot_count_a), .preempt(preempt_a)
    );

    modulo_slot_scheduler #(.N(4), .SLOT_LEN(1), .GAP_LEN(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .done(done_b),
        .grant(grant_b), .grant_valid(grant_valid_b), .grant_id(grant_id_b),
        .slot_count(slot_count_b), .preempt(preempt_b)
    );

    wire [39:0] act_a = {grant_a, grant_valid_a, grant_id_a, slot_count_a, preempt_a};
    wire [39:0] act_b = {grant_b, grant_valid_b, grant_id_b, slot_count_b, preempt_b};

    function automatic int slot_len(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int gap_len(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_run[d]   = 0;
            m_gap[d]   = -1;
            m_last[d]  = 3;
            m_id[d]    = 0;
            m_pre[d]   = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r, input logic [3:0] dn);
        int o;
        o = m_owner[d];
        m_pre[d] = 1'b0;
        if (o >= 0) begin
            if (dn[o] || !r[o]) begin
                m_owner[d] = -1;
                m_gap[d]   = 0;
            end else if (m_run[d] == slot_len(d) - 1) begin
                m_owner[d] = -1;
                m_gap[d]   = 0;
                m_pre[d]   = 1'b1;
            end else begin
                m_run[d] = m_run[d] + 1;
            end
        end else if (m_gap[d] >= 0) begin
            m_gap[d] = (m_gap[d] == gap_len(d) - 1) ? -1 : m_gap[d] + 1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (m_last[d] + k) % 4;
                if (m_owner[d] < 0 && r[idx]) begin
                    m_owner[d] = idx;
                    m_last[d]  = idx;
                    m_id[d]    = idx;
                    m_run[d]   = 0;
                end
            end
        end
    endtask

    function automatic logic [39:0] exp_vec(input int d);
        logic [3:0]  g;
        logic [31:0] c;
        g = '0;
        if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
        c = (m_owner[d] >= 0) ? 32'(m_run[d]) : ((m_gap[d] >= 0) ? 32'(m_gap[d]) : 32'd0);
        return {g, (m_owner[d] >= 0), 2'(m_id[d]), c, m_pre[d]};
    endfunction

    task automatic step();
        model_step(0, req_a, done_a);
        model_step(1, req_b, done_b);
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d a: req=%b done=%b grant=%b id=%0d cnt=%0d pre=%b | b: req=%b grant=%b cnt=%0d pre=%b",
                 cyc, req_a, done_a, grant_a, grant_id_a, slot_count_a, preempt_a,
                 req_b, grant_b, slot_count_b, preempt_b);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_a = '0; done_a = '0; req_b = '0; done_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (act_a !== exp_vec(0)) begin
            fails++;
            $display("FAIL reset_a: got %h expected %h", act_a, exp_vec(0));
        end
        checks++;
        if (act_b !== exp_vec(1)) begin
            fails++;
            $display("FAIL reset_b: got %h expected %h", act_b, exp_vec(1));
        end
    endtask

    task automatic test_single();
        do_reset();
        req_a = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (act_a !== exp_vec(0)) begin
                fails++;
                $display("FAIL single cyc %0d: got %h expected %h", i, act_a, exp_vec(0));
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] order[$];
        logic [3:0] prev;
        logic [3:0] want[5];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        prev = '0;
        req_a = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (act_a !== exp_vec(0)) begin
                fails++;
                $display("FAIL round_robin cyc %0d: got %h expected %h", i, act_a, exp_vec(0));
            end
            if (grant_a != 0 && prev == 0) order.push_back(grant_a);
            prev = grant_a;
        end
        checks++;
        if (order.size() < 5) begin
            fails++;
            $display("FAIL rr_count: got %0d grants required 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (order[k] !== want[k]) begin
                    fails++;
                    $display("FAIL rr_order[%0d]: got %b required %b", k, order[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_done_release();
        do_reset();
        req_a = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            done_a = (i == 1) ? 4'b0001 : ((i == 2) ? 4'b0100 : 4'b0000);
            step();
            checks++;
            if (act_a !== exp_vec(0)) begin
                fails++;
                $display("FAIL done_release cyc %0d: got %h expected %h", i, act_a, exp_vec(0));
            end
            if (i == 2) begin
                checks++;
                if (grant_a !== 4'b0000 || preempt_a !== 1'b0) begin
                    fails++;
                    $display("FAIL done_drop: got grant=%b pre=%b required 0000/0", grant_a, preempt_a);
                end
            end
        end
        done_a = '0;
    endtask

    task automatic test_done_at_expiry();
        do_reset();
        req_a = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            done_a = (i == 4) ? 4'b0010 : 4'b0000;
            if (i == 8) req_a = 4'b0000;
            step();
            checks++;
            if (act_a !== exp_vec(0)) begin
                fails++;
                $display("FAIL done_expiry cyc %0d: got %h expected %h", i, act_a, exp_vec(0));
            end
            if (i == 4) begin
                checks++;
                if (preempt_a !== 1'b0 || grant_a !== 4'b0000) begin
                    fails++;
                    $display("FAIL expiry_release: got grant=%b pre=%b required 0000/0", grant_a, preempt_a);
                end
            end
        end
        done_a = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_a = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (act_a !== exp_vec(0)) begin
                fails++;
                $display("FAIL async_pre cyc %0d: got %h expected %h", i, act_a, exp_vec(0));
            end
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act_a !== exp_vec(0)) begin
            fails++;
            $display("FAIL async_drop: got %h expected %h", act_a, exp_vec(0));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req_a = 4'b0101;
        step();
        checks++;
        if (grant_a !== 4'b0001 || act_a !== exp_vec(0)) begin
            fails++;
            $display("FAIL async_restart: got %h expected %h", act_a, exp_vec(0));
        end
    endtask

    task automatic test_gap3();
        do_reset();
        req_b = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (act_b !== exp_vec(1)) begin
                fails++;
                $display("FAIL gap3 cyc %0d: got %h expected %h", i, act_b, exp_vec(1));
            end
        end
        req_b = 4'b0000;
        for (int i = 0; i < 20 && m_gap[1] < 0; i++) begin
            step();
            checks++;
            if (act_b !== exp_vec(1)) begin
                fails++;
                $display("FAIL gap3_drain cyc %0d: got %h expected %h", i, act_b, exp_vec(1));
            end
        end
        checks++;
        if (m_gap[1] < 0) begin
            fails++;
            $display("FAIL gap3_timeout: gap state not reached within 20 cycles");
        end
        req_b = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (act_b !== exp_vec(1)) begin
                fails++;
                $display("FAIL gap3_late_req cyc %0d: got %h expected %h", i, act_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_a  = 4'($urandom);
            done_a = 4'($urandom) & 4'($urandom);
            req_b  = 4'($urandom);
            done_b = 4'($urandom) & 4'($urandom);
            step();
            checks++;
            if (act_a !== exp_vec(0)) begin
                fails++;
                $display("FAIL random_a cyc %0d: got %h expected %h", i, act_a, exp_vec(0));
            end
            checks++;
            if (act_b !== exp_vec(1)) begin
                fails++;
                $display("FAIL random_b cyc %0d: got %h expected %h", i, act_b, exp_vec(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_done_release();
        test_done_at_expiry();
        test_async_reset();
        test_gap3();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
